clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Downstream checker for the two-phase divided-clock pulse pair from the clock divider.
//  Runs in the source clock domain and measures each phase's pulse period (and, optionally,
//  its high time) in clk_in cycles.
//  Reports per-phase lock, error pulses and saturating error counts to status logic.
// PARAMETERS
//  DIV_PERIOD  3  expected rise-to-rise spacing, clk_in cycles (>=2)
//  HIGH_CYCLES 1  expected high time, clk_in cycles (< DIV_PERIOD)
//  LOCK_COUNT  4  consecutive good periods needed to declare lock (>=1)
//  CNT_W       8  measurement counter width; must hold 4*DIV_PERIOD
// PORTS
//  clk_in     in   1  system clock; all logic on posedge
//  rst        in   1  synchronous reset, active-low
//  div_in     in   2  divided pulse pair; [0] posedge phase, [1] negedge phase
//  clear      in   1  synchronous soft clear of FSM and counters, active-high
//  locked     out  2  per phase: LOCK_COUNT consecutive good periods seen
//  period_err out  2  1-cycle pulse: measured period != DIV_PERIOD
//  stall_err  out  2  1-cycle pulse: no rise within 4*DIV_PERIOD cycles
//  duty_err   out  2  1-cycle pulse: high time != HIGH_CYCLES (DUTY_CHECK_EN only)
//  err_cnt0   out  8  phase-0 error count, saturates at 255
//  err_cnt1   out  8  phase-1 error count, saturates at 255
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all outputs 0, FSM IDLE, all counters and sync flops 0.
//  - Input path per phase: 2-flop sync s1->s2, plus history flop s3.
//    rise = s2&~s3; fall = ~s2&s3.
//    div_in rising before edge k gives rise during cycle k+1 (after edge k+1).
//    Error pulses and the locked update are registered one edge later.
//  - per_cnt: loads 1 on rise; else increments, saturating at 2^CNT_W-1.
//    Value at a rise is the measured period.
//  - FSM per phase: {IDLE, MEAS, LOCKED}
//      IDLE:   rise -> MEAS, good_cnt=0. No comparison on the first edge.
//      MEAS:   rise & per_cnt==DIV_PERIOD -> good_cnt++;
//              if good_cnt+1==LOCK_COUNT -> LOCKED.
//              rise & mismatch -> period_err, err_cnt++, good_cnt=0, stay MEAS.
//      LOCKED: rise & match -> stay. Mismatch -> period_err, err_cnt++, MEAS, good_cnt=0.
//      MEAS/LOCKED: no rise & per_cnt==4*DIV_PERIOD -> stall_err, err_cnt++, IDLE.
//  - locked[i] = (state==LOCKED), registered.
//  - Simultaneous events:
//      clear beats everything: IDLE, counters 0, no pulses. Sync flops are kept.
//      A rise suppresses the timeout in the same cycle.
//      Period and duty errors on the same cycle increment err_cnt by 1 only.
//  - err_cnt holds at 255; only rst or clear resets it.
//  - rst mid-operation: full reset at that edge; locked drops the same edge.
// CONFIGURATION
//  DUTY_CHECK_EN defined:
//    hi_cnt loads 1 on rise, increments while s2==1.
//    On fall, hi_cnt!=HIGH_CYCLES -> duty_err, err_cnt++; LOCKED/MEAS -> MEAS, good_cnt=0.
//    Checked only outside IDLE.
//  DUTY_CHECK_EN undefined:
//    no hi_cnt; duty_err tied 0; the FSM depends on period and stall only.
// STRUCTURE
//  - Package clk_div_monitor_pkg: state typedef (IDLE/MEAS/LOCKED) and default parameter
//    constants.
//  - Sub-module div_chan_mon: one phase (sync, edge detect, counters, FSM, err_cnt).
//    Instantiated twice; the top only fans out ports.
// TESTING
//  1. rst low 2 cycles, then period-3 / high-1 pulses on both phases
//     -> locked==2'b11 one edge after the 5th rise seen; no error pulses; err_cnt0/1==0.
//  2. After lock, one phase-0 period of 4
//     -> period_err[0] single-cycle pulse, locked[0]=0, err_cnt0=1.
//     Relocks after 4 good periods; phase 1 unaffected.
//  3. After lock, hold div_in[1] low
//     -> stall_err[1] when per_cnt==12, locked[1]=0, IDLE, err_cnt1=1.
//     Next rise alone does not compare.
//  4. 300 consecutive period-4 pulses on phase 0
//     -> err_cnt0 reaches 255 and holds; period_err pulses continue.
//  5. clear in the same cycle as a rise while LOCKED
//     -> no pulses, locked=0, err_cnt=0, IDLE. rst low mid-lock -> all outputs 0 next edge.
//  6. DUTY_CHECK_EN, period 3, high 2 -> duty_err on each fall, no lock.
//     Without the macro the same stimulus locks with duty_err==0.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// Shared state encoding, default parameters and helpers for clk_div_monitor.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_DIV_PERIOD  = 3;
  localparam int unsigned DEF_HIGH_CYCLES = 1;
  localparam int unsigned DEF_LOCK_COUNT  = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned ERR_CNT_W       = 8;

  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/div_chan_mon.sv
// One phase of the divided-clock monitor: sync, edge detect, period/stall checks, lock FSM.
// High-time checking is compiled in only when DUTY_CHECK_EN is defined.
module div_chan_mon
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned DIV_PERIOD  = DEF_DIV_PERIOD,
`ifdef DUTY_CHECK_EN
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
`endif
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 period_err_o,
  output logic                 stall_err_o,
  output logic                 duty_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CNT_W-1:0]  PER_EXP   = CNT_W'(DIV_PERIOD);
  localparam logic [CNT_W-1:0]  STALL_LIM = CNT_W'(4 * DIV_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic s1_q, s2_q, s3_q;
  logic rise;
  logic duty_hit;

  mon_state_e            state_q, state_d;
  logic [CNT_W-1:0]      per_cnt_q, per_cnt_d;
  logic [GOOD_W-1:0]     good_cnt_q, good_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  locked_q, locked_d;
  logic                  period_err_q, period_err_d;
  logic                  stall_err_q, stall_err_d;

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HI_EXP = CNT_W'(HIGH_CYCLES);
  logic             fall;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             duty_err_q;
  assign fall = ~s2_q & s3_q;
`endif

  // Synchroniser survives a soft clear so an in-flight edge is not lost or invented.
  // NOTE: non-blocking assignments let every flop sample the pre-edge value of its source.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= div_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    period_err_d = 1'b0;
    stall_err_d  = 1'b0;
    duty_hit     = 1'b0;
    if (rise)                   per_cnt_d = CNT_W'(1);
    else if (per_cnt_q == '1)   per_cnt_d = per_cnt_q;
    else                        per_cnt_d = per_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = MEAS;
          good_cnt_d = '0;
        end
      end
      MEAS, LOCKED: begin
        if (rise) begin
          if (per_cnt_q != PER_EXP) begin
            period_err_d = 1'b1;
            state_d      = MEAS;
            good_cnt_d   = '0;
          end else if (state_q == MEAS) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end
        end else if (per_cnt_q == STALL_LIM) begin
          stall_err_d = 1'b1;
          state_d     = IDLE;
          good_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef DUTY_CHECK_EN
    if (rise)                  hi_cnt_d = CNT_W'(1);
    else if (!s2_q)            hi_cnt_d = hi_cnt_q;
    else if (hi_cnt_q == '1)   hi_cnt_d = hi_cnt_q;
    else                       hi_cnt_d = hi_cnt_q + 1'b1;
    if (fall && (state_q != IDLE) && (hi_cnt_q != HI_EXP)) begin
      duty_hit = 1'b1;
      if (!stall_err_d) begin
        state_d    = MEAS;
        good_cnt_d = '0;
      end
    end
`endif

    err_cnt_d = (period_err_d | stall_err_d | duty_hit) ? err_inc(err_cnt_q) : err_cnt_q;

    if (clear_i) begin
      state_d      = IDLE;
      per_cnt_d    = '0;
      good_cnt_d   = '0;
      err_cnt_d    = '0;
      period_err_d = 1'b0;
      stall_err_d  = 1'b0;
      duty_hit     = 1'b0;
`ifdef DUTY_CHECK_EN
      hi_cnt_d     = '0;
`endif
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      stall_err_q  <= stall_err_d;
    end
  end

`ifdef DUTY_CHECK_EN
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      hi_cnt_q   <= '0;
      duty_err_q <= 1'b0;
    end else begin
      hi_cnt_q   <= hi_cnt_d;
      duty_err_q <= duty_hit;
    end
  end
  assign duty_err_o = duty_err_q;
`else
  assign duty_err_o = 1'b0;
`endif

  assign locked_o     = locked_q;
  assign period_err_o = period_err_q;
  assign stall_err_o  = stall_err_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Two-phase divided-clock monitor: one div_chan_mon per phase of div_in.
// Define DUTY_CHECK_EN to add per-phase high-time checking (duty_err).
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned DIV_PERIOD  = DEF_DIV_PERIOD,
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [1:0] div_in,
  input  logic       clear,
  output logic [1:0] locked,
  output logic [1:0] period_err,
  output logic [1:0] stall_err,
  output logic [1:0] duty_err,
  output logic [7:0] err_cnt0,
  output logic [7:0] err_cnt1
);

  // The stall limit must fit in the measurement counter without saturating first.
  if ((DIV_PERIOD < 2) || (HIGH_CYCLES >= DIV_PERIOD) || (LOCK_COUNT < 1) ||
      (CNT_W >= 31) || ((4 * DIV_PERIOD) > ((1 << CNT_W) - 1))) begin : g_bad_cfg
    $error("clk_div_monitor: inconsistent parameter set");
  end

  div_chan_mon #(
    .DIV_PERIOD  (DIV_PERIOD),
`ifdef DUTY_CHECK_EN
    .HIGH_CYCLES (HIGH_CYCLES),
`endif
    .LOCK_COUNT  (LOCK_COUNT),
    .CNT_W       (CNT_W)
  ) u_chan0 (
    .clk_in       (clk_in),
    .rst          (rst),
    .div_i        (div_in[0]),
    .clear_i      (clear),
    .locked_o     (locked[0]),
    .period_err_o (period_err[0]),
    .stall_err_o  (stall_err[0]),
    .duty_err_o   (duty_err[0]),
    .err_cnt_o    (err_cnt0)
  );

  div_chan_mon #(
    .DIV_PERIOD  (DIV_PERIOD),
`ifdef DUTY_CHECK_EN
    .HIGH_CYCLES (HIGH_CYCLES),
`endif
    .LOCK_COUNT  (LOCK_COUNT),
    .CNT_W       (CNT_W)
  ) u_chan1 (
    .clk_in       (clk_in),
    .rst          (rst),
    .div_i        (div_in[1]),
    .clear_i      (clear),
    .locked_o     (locked[1]),
    .period_err_o (period_err[1]),
    .stall_err_o  (stall_err[1]),
    .duty_err_o   (duty_err[1]),
    .err_cnt_o    (err_cnt1)
  );

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: event-time model compared every cycle, plus literal checkpoints.
module tb_clk_div_monitor;

  localparam int DIV   = 3;
  localparam int HI    = 1;
  localparam int LCK   = 4;
  localparam int STALL = 4 * DIV;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       clear;
  logic [1:0] div_in;
  logic [1:0] locked, period_err, stall_err, duty_err;
  logic [7:0] err_cnt0, err_cnt1;

  int total = 0;
  int bad   = 0;

  clk_div_monitor dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_in     (div_in),
    .clear      (clear),
    .locked     (locked),
    .period_err (period_err),
    .stall_err  (stall_err),
    .duty_err   (duty_err),
    .err_cnt0   (err_cnt0),
    .err_cnt1   (err_cnt1)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse generators: per-phase period, high time, phase position, one-shot extra low cycles.
  int per [2];
  int hi  [2];
  int ph  [2];
  int ext [2];
  bit en  [2];

  task automatic drive_step();
    for (int i = 0; i < 2; i++) begin
      if (ph[i] >= per[i]) ph[i] = 0;
      div_in[i] = en[i] && (ph[i] < hi[i]);
      if (en[i] && (ph[i] == per[i] - 1) && (ext[i] > 0)) ext[i]--;
      else ph[i] = (ph[i] + 1) % per[i];
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      drive_step();
    end
  endtask

  // Model: the input is seen through a 2-cycle delay; events are timestamped by edge number
  // and periods / high times are differences of timestamps.
  logic [1:0] sn0 = '0, sn1 = '0, sn2 = '0;
  int         ecnt = 0;
  logic [1:0] m_arm = '0, m_lk = '0, m_per = '0, m_stl = '0, m_dty = '0;
  int         m_run [2] = '{0, 0};
  int         m_err [2] = '{0, 0};
  int         m_last[2] = '{0, 0};

  initial begin
    logic [1:0] rz;
`ifdef DUTY_CHECK_EN
    logic [1:0] fl;
    logic       arm0;
`endif
    forever begin
      @(posedge clk_in);
      ecnt++;
      m_per = '0;
      m_stl = '0;
      m_dty = '0;
      rz = sn1 & ~sn2;
`ifdef DUTY_CHECK_EN
      fl = ~sn1 & sn2;
`endif
      if (!rst) begin
        sn0 = '0; sn1 = '0; sn2 = '0;
        m_arm = '0; m_lk = '0;
        m_run = '{0, 0}; m_err = '{0, 0};
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (clear) begin
            m_arm[i] = 1'b0; m_lk[i] = 1'b0; m_run[i] = 0; m_err[i] = 0;
          end else begin
`ifdef DUTY_CHECK_EN
            arm0 = m_arm[i];
`endif
            if (rz[i]) begin
              if (!m_arm[i]) begin
                m_arm[i] = 1'b1;
                m_run[i] = 0;
              end else if (ecnt - m_last[i] == DIV) begin
                if (!m_lk[i]) begin
                  m_run[i]++;
                  if (m_run[i] == LCK) m_lk[i] = 1'b1;
                end
              end else begin
                m_per[i] = 1'b1; m_run[i] = 0; m_lk[i] = 1'b0;
              end
              m_last[i] = ecnt;
            end else if (m_arm[i] && (ecnt - m_last[i] == STALL)) begin
              m_stl[i] = 1'b1; m_arm[i] = 1'b0; m_run[i] = 0; m_lk[i] = 1'b0;
            end
`ifdef DUTY_CHECK_EN
            if (fl[i] && arm0 && (ecnt - m_last[i] != HI)) begin
              m_dty[i] = 1'b1;
              if (!m_stl[i]) begin
                m_run[i] = 0; m_lk[i] = 1'b0;
              end
            end
`endif
            if ((m_per[i] | m_stl[i] | m_dty[i]) && (m_err[i] < 255)) m_err[i]++;
          end
        end
        sn2 = sn1; sn1 = sn0; sn0 = div_in;
      end
    end
  end

  int pe0_cnt = 0;
  int dty_cnt = 0;

  initial begin
    forever begin
      @(negedge clk_in);
      if (ecnt > 0) begin
        check("locked",     int'(locked),     int'(m_lk));
        check("period_err", int'(period_err), int'(m_per));
        check("stall_err",  int'(stall_err),  int'(m_stl));
        check("duty_err",   int'(duty_err),   int'(m_dty));
        check("err_cnt0",   int'(err_cnt0),   m_err[0]);
        check("err_cnt1",   int'(err_cnt1),   m_err[1]);
        if (period_err[0]) pe0_cnt++;
        if (duty_err != 2'b00) dty_cnt++;
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: time limit reached at t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst   = 1'b0;
    clear = 1'b0;
    div_in = '0;
    per = '{DIV, DIV}; hi = '{HI, HI}; ph = '{0, 0}; ext = '{0, 0}; en = '{0, 0};
    run_cycles(2);

    // 1: lock on both phases; phase 1 lags phase 0 by one cycle
    rst = 1'b1;
    en  = '{1, 1};
    ph  = '{0, 2};
    drive_step();
    check("rst_locked",  int'(locked),   0);
    check("rst_errcnt0", int'(err_cnt0), 0);
    check("rst_errcnt1", int'(err_cnt1), 0);
    run_cycles(15);
    check("t1_lock_ph0_only", int'(locked), 1);
    run_cycles(1);
    check("t1_lock_both", int'(locked),   3);
    check("t1_errcnt0",   int'(err_cnt0), 0);
    check("t1_errcnt1",   int'(err_cnt1), 0);

    // 2: one phase-0 period of 4, then relock
    ext[0] = 1;
    run_cycles(10);
    check("t2_errcnt0", int'(err_cnt0), 1);
    check("t2_unlock0", int'(locked),   2);
    run_cycles(20);
    check("t2_relock",  int'(locked),   3);
    check("t2_errcnt1", int'(err_cnt1), 0);

    // 3: phase 1 held low -> single stall, no repeat while idle
    en[1] = 0;
    run_cycles(16);
    check("t3_errcnt1", int'(err_cnt1), 1);
    check("t3_unlock1", int'(locked),   1);
    run_cycles(20);
    check("t3_no_repeat", int'(err_cnt1), 1);
    en[1] = 1;
    run_cycles(30);
    check("t3_relock",       int'(locked),   3);
    check("t3_first_no_cmp", int'(err_cnt1), 1);

    // 4: 300 periods of 4 on phase 0 -> counter saturates, pulses continue
    pe0_cnt = 0;
    per[0]  = 4;
    run_cycles(1200);
    check("t4_sat",    int'(err_cnt0), 255);
    check("t4_pulses", int'(pe0_cnt >= 295), 1);
    check("t4_locked", int'(locked), 2);
    per[0] = DIV;
    run_cycles(30);
    check("t4_relock", int'(locked),   3);
    check("t4_hold",   int'(err_cnt0), 255);

    // 5: clear on the cycle a phase-0 rise is seen while locked
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_cycles(1);
      if (div_in[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_align", int'(found), 1);
    run_cycles(2);
    clear = 1'b1;
    run_cycles(1);
    clear = 1'b0;
    check("t5_locked",   int'(locked),     0);
    check("t5_errcnt0",  int'(err_cnt0),   0);
    check("t5_errcnt1",  int'(err_cnt1),   0);
    check("t5_pulses",   int'(period_err), 0);
    run_cycles(30);
    check("t5_relock", int'(locked), 3);

    // 5b: reset while locked with a pending error count
    ext[1] = 1;
    run_cycles(10);
    check("t5_pre_rst_err1", int'(err_cnt1), 1);
    rst = 1'b0;
    run_cycles(1);
    check("t5_rst_locked",  int'(locked),   0);
    check("t5_rst_errcnt1", int'(err_cnt1), 0);
    rst = 1'b1;
    run_cycles(30);
    check("t5_rst_relock", int'(locked), 3);

    // 6: period 3 with high time 2
    dty_cnt = 0;
    hi = '{2, 2};
    run_cycles(40);
`ifdef DUTY_CHECK_EN
    check("t6_no_lock",  int'(locked), 0);
    check("t6_duty_seen", int'(dty_cnt > 0), 1);
`else
    check("t6_locked",  int'(locked), 3);
    check("t6_no_duty", dty_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
